// File: rtl/iter_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter: walks the shift amount down in steps of two,
// finishing an odd remainder with a single-bit step.
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   acc, acc_step;
    logic [SHAMT_W-1:0] rem, rem_step;
    logic [1:0]         op_q;
    logic               step2;
    logic               accept;

    // Handshake: start is taken on any edge where busy=0 (IDLE or DONE), unless a
    // flush in DONE cancels it; done pulses for one cycle with result already valid.
    assign accept = start && ((state == IDLE) || ((state == DONE) && !flush));

    always_comb begin
        step2    = (rem >= SHAMT_W'(2));
        rem_step = rem - (step2 ? SHAMT_W'(2) : SHAMT_W'(1));
        acc_step = acc;
        case (op_q)
            2'b01:   acc_step = step2 ? {2'b00, acc[WIDTH-1:2]} : {1'b0, acc[WIDTH-1:1]};
            2'b11:   acc_step = step2 ? {{2{acc[WIDTH-1]}}, acc[WIDTH-1:2]}
                                      : {acc[WIDTH-1], acc[WIDTH-1:1]};
            default: acc_step = step2 ? {acc[WIDTH-3:0], 2'b00} : {acc[WIDTH-2:0], 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = (shamt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (flush)                  state_next = IDLE;
                else if (rem_step == '0)    state_next = DONE;
            end
            DONE: begin
                if (flush)       state_next = IDLE;
                else if (accept) state_next = (shamt != '0) ? SHIFT : DONE;
                else             state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // result only moves on a DONE entry edge; a zero shift completes straight from a.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            rem    <= '0;
            op_q   <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                acc  <= a;
                rem  <= shamt;
                op_q <= op;
            end else if ((state == SHIFT) && !flush) begin
                acc <= acc_step;
                rem <= rem_step;
            end
            if (state_next == DONE) begin
                result <= accept ? a : acc_step;
            end
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: latency, busy window, flush and reset behaviour.
module tb_iter_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int passed = 0;
    int total  = 0;
    logic saw_done;

    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .shamt     (shamt),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one op, checks busy through the shift window and done/result at the
    // expected cycle; returns while the DUT sits in its DONE cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                          input logic [4:0] sh, input logic [31:0] exp);
        int lat;
        lat   = 1 + (int'(sh) + 1) / 2;
        op    = o;
        a     = av;
        shamt = sh;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~av;
        op    = ~o;
        shamt = ~sh;
        for (int c = 1; c < lat; c++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_nodone"}, {31'd0, done}, 32'd0);
            tick();
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
        check({tag, "_result"}, result, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; shamt = '0; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        tick();

        run_op("sll31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
        tick();
        check("sll31_after_done", {31'd0, done}, 32'd0);
        check("sll31_hold", result, 32'h8000_0000);

        run_op("sra5", 2'b11, 32'h8000_0000, 5'd5, 32'hFC00_0000);
        tick();
        run_op("srl5", 2'b01, 32'h8000_0000, 5'd5, 32'h0400_0000);
        tick();
        run_op("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        tick();
        run_op("sra31", 2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        tick();
        run_op("op10", 2'b10, 32'h1234_5678, 5'd4, 32'h2345_6780);
        tick();
        run_op("sra_pos", 2'b11, 32'h7FFF_FFFF, 5'd30, 32'h0000_0001);
        tick();
        run_op("srl31", 2'b01, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001);
        tick();
        run_op("sll1", 2'b00, 32'h8000_0001, 5'd1, 32'h0000_0002);
        tick();

        // Back-to-back: each new start lands in the previous DONE cycle.
        run_op("b2b_a", 2'b01, 32'hF000_0000, 5'd4, 32'h0F00_0000);
        run_op("b2b_b", 2'b00, 32'h0000_0003, 5'd3, 32'h0000_0018);
        run_op("b2b_c", 2'b00, 32'hA5A5_A5A5, 5'd0, 32'hA5A5_A5A5);
        tick();

        // start during SHIFT is ignored.
        op = 2'b00; a = 32'h0000_00FF; shamt = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_c1_busy", {31'd0, busy}, 32'd1);
        tick();
        op = 2'b01; a = 32'hFFFF_FFFF; shamt = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_c3_busy", {31'd0, busy}, 32'd1);
        tick();
        check("ign_c4_busy", {31'd0, busy}, 32'd1);
        tick();
        check("ign_c5_done", {31'd0, done}, 32'd1);
        check("ign_c5_result", result, 32'h0000_FF00);
        tick();
        check("ign_c6_done", {31'd0, done}, 32'd0);
        check("ign_c6_busy", {31'd0, busy}, 32'd0);

        // flush during SHIFT.
        op = 2'b00; a = 32'h0000_000F; shamt = 5'd10; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_done", {31'd0, done}, 32'd0);
        check("flush_result", result, 32'h0000_FF00);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        check("flush_no_done", {31'd0, saw_done}, 32'd0);

        // flush with start in DONE: start dropped, completion stands.
        run_op("fd", 2'b01, 32'h0000_0100, 5'd4, 32'h0000_0010);
        flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'h0000_0077; shamt = 5'd0;
        tick();
        flush = 1'b0; start = 1'b0;
        check("fd_busy", {31'd0, busy}, 32'd0);
        check("fd_done", {31'd0, done}, 32'd0);
        check("fd_result", result, 32'h0000_0010);
        check("fd_state", {30'd0, dbg_state}, 32'd0);

        // flush in IDLE has no effect on an accepted start.
        flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'h0000_0003; shamt = 5'd2;
        tick();
        flush = 1'b0; start = 1'b0;
        check("fi_busy", {31'd0, busy}, 32'd1);
        tick();
        check("fi_done", {31'd0, done}, 32'd1);
        check("fi_result", result, 32'h0000_000C);
        tick();

        // reset in the middle of a long operation.
        op = 2'b00; a = 32'h0000_0001; shamt = 5'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_done", {31'd0, done}, 32'd0);
        check("mrst_result", result, 32'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        check("mrst_no_done", {31'd0, saw_done}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
- Multi-cycle shifter for the MIPS ALU path. Executes SLL/SRL/SRA and their variable forms (SLLV/SRLV/SRAV) by applying the fixed shift-by-2 step repeatedly, with a 1-bit step for an odd remainder.
- Replaces a full combinational barrel shifter. The pipeline controller sees a start/busy/done handshake and stalls on busy.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, width of the shift-amount field. Must satisfy 2**SHAMT_W <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request new shift; sampled only when busy=0.
- op  input  2  00=SLL, 01=SRL, 11=SRA, 10=treated as SLL.
- a  input  WIDTH  operand; sampled with start.
- shamt  input  SHAMT_W  shift amount, unsigned; sampled with start.
- flush  input  1  synchronous abort of the in-flight operation.
- busy  output  1  high while shifting; controller stalls the issuing stage.
- done  output  1  single-cycle pulse; result valid and updated this cycle.
- result  output  WIDTH  registered shifted value; holds until the next completion.

Behaviour:
- States are IDLE, SHIFT and DONE, with registers acc[WIDTH], rem[SHAMT_W] and op_q[2].
- Reset (rst=1 at an edge):
  - state=IDLE, busy=0, done=0, result=0, acc=0, rem=0.
  - Reset has priority over flush and start, and applies mid-operation with no done pulse.
- busy=1 only in SHIFT. done=1 only in DONE. Both outputs decode from registered state, with no combinational path from inputs.
- Accepting a request:
  - start is accepted in IDLE or DONE, which allows back-to-back operations with no bubble.
  - start is ignored in SHIFT.
  - On acceptance: acc<=a, rem<=shamt, op_q<=op.
  - Next state is SHIFT if shamt!=0, else DONE.
- SHIFT, per cycle:
  - Step size s=2 if rem>=2, else s=1.
  - acc is shifted by s: SLL fills zeros at the LSBs, SRL fills zeros at the MSBs, SRA replicates acc[WIDTH-1].
  - rem<=rem-s. If rem-s==0, next state is DONE.
- DONE:
  - result is written with acc on the entry edge, so it is valid in the same cycle done=1.
  - Next state is SHIFT/DONE if a new start is accepted, else IDLE.
- Latency: with start high in cycle 0, done is high in cycle 1+ceil(shamt/2).
  - shamt=0: cycle 1.
  - shamt=1 or 2: cycle 2.
  - shamt=31: cycle 17.
  - Throughput is one operation per 1+ceil(shamt/2) cycles.
- Flush:
  - flush=1 in SHIFT or DONE forces IDLE at the next edge.
  - No done pulse is produced for the aborted operation and result is unchanged. If flush lands in DONE, done has already pulsed and result has already been written; that completion stands.
  - flush has priority over start in the same cycle: start is dropped.
  - flush in IDLE has no effect.
- Boundaries:
  - shamt=WIDTH-1 is the maximum; there is no wrap.
  - SRA of a negative operand saturates to all-ones as shamt grows.
  - op=10 behaves exactly as SLL.
  - Inputs a, op and shamt may change freely while busy; only the values sampled at acceptance are used.
- result is never X after reset and changes only on a DONE entry edge.

Test Plan:
- SLL a=0x00000001, shamt=31, start in cycle 0 -> busy high in cycles 1-16, done in cycle 17, result=0x80000000.
- SRA a=0x80000000, shamt=5 -> steps 2,2,1; done in cycle 4; result=0xFC000000. SRL with the same inputs gives result=0x04000000.
- shamt=0, op=SRL, a=0xDEADBEEF -> busy never high, done in cycle 1, result=0xDEADBEEF.
- Busy-window checks:
  - start pulse with a new operand at cycle 2 of a shamt=8 SLL -> ignored; a single done in cycle 5 with the first operation's result.
  - start asserted in the DONE cycle -> the second operation completes at the expected latency from that cycle.
- flush during SHIFT of SLL 0x0000000F by 10 -> no done; result keeps its prior value; busy=0 on the next cycle. flush with start in the same cycle -> start dropped.
- rst at cycle 3 of a shamt=20 operation -> next cycle busy=0, done=0, result=0, and no later done pulse.
